mem_stage_ctrl: RTL and testbench

- MEM-stage controller that consumes the EX/MEM pipeline register outputs and executes loads and stores against a multi-cycle data memory using a req/ack handshake.
- Drives `stall` back to the IF/ID, ID/EX and EX/MEM enables while an access is outstanding.
- Produces the registered MEM/WB payload.

---
 rtl/mem_stage_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller. Runs loads and stores against a multi-cycle
// data memory through a req/ack handshake and holds the upstream pipeline with
// stall while an access is outstanding. Produces the registered MEM/WB payload.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access when dm_ack has not
// arrived within TIMEOUT WAIT cycles. The abort is reported as an exception.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   em_*                       EX/MEM pipeline register outputs
//   dm_req/we/addr/wdata       data-memory request, held stable until the ack edge
//   dm_ack, dm_rdata           memory completion pulse and read data
//   stall                      combinational hold for the IF/ID, ID/EX and EX/MEM enables
//   mw_*                       registered MEM/WB payload (mw_exc = misaligned or aborted)
module mem_stage_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              em_mem_read,
    input  logic              em_mem_write,
    input  logic              em_reg_write,
    input  logic              em_mem_to_reg,
    input  logic [31:0]       em_alu_result,
    input  logic [31:0]       em_store_data,
    input  logic [4:0]        em_rd,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              mw_reg_write,
    output logic              mw_mem_to_reg,
    output logic [31:0]       mw_alu_result,
    output logic [31:0]       mw_mem_data,
    output logic [4:0]        mw_rd,
    output logic              mw_exc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // A zero timeout would abort before the first WAIT cycle completes.
    if (TIMEOUT == 0) begin : g_timeout_invalid
        logic cfg_invalid;
        assign cfg_invalid = 1'b1;
    end

    state_t state;
    state_t state_nxt;

    logic            is_mem;
    logic            is_store;
    logic            is_load;
    logic            aligned;
    logic            stall_int;
    logic            mw_load;
    logic            mw_exc_nxt;
    logic [XLEN-1:0] mw_data_nxt;
    logic            dm_start;
    logic            dm_done;
    logic            timeout_hit;

    // Both read and write set is treated as a store.
    assign is_mem   = em_mem_read | em_mem_write;
    assign is_store = em_mem_write;
    assign is_load  = em_mem_read & ~em_mem_write;
    assign aligned  = (em_alu_result[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;

    // Count WAIT cycles without ack; cleared on every entry to WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (dm_start) begin
            to_cnt <= '0;
        end else if (state == S_WAIT && !dm_ack) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == S_WAIT) && !dm_ack && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and MEM/WB capture decisions.
    always_comb begin
        state_nxt   = state;
        stall_int   = 1'b0;
        mw_load     = 1'b0;
        mw_exc_nxt  = 1'b0;
        mw_data_nxt = '0;
        dm_start    = 1'b0;
        dm_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mem && aligned) begin
                    stall_int = 1'b1;
                    dm_start  = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    // Non-memory op, or misaligned access which never reaches memory.
                    mw_load    = 1'b1;
                    mw_exc_nxt = is_mem;
                end
            end
            S_WAIT: begin
                stall_int = ~dm_ack;
                if (dm_ack) begin
                    mw_load     = 1'b1;
                    mw_data_nxt = is_load ? XLEN'(dm_rdata) : '0;
                    dm_done     = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (timeout_hit) begin
                    stall_int  = 1'b0;
                    mw_load    = 1'b1;
                    mw_exc_nxt = 1'b1;
                    dm_done    = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset forces the hold off even though the EX/MEM inputs may still show an access.
    assign stall = stall_int & reset;

    // Memory request registers; launched on the IDLE->WAIT edge, held until completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else if (dm_start) begin
            dm_req   <= 1'b1;
            dm_we    <= is_store;
            dm_addr  <= ADDR_W'(em_alu_result);
            dm_wdata <= DATA_W'(em_store_data);
        end else if (dm_done) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
        end
    end

    // MEM/WB payload register; an exception suppresses the register-file write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mw_reg_write  <= 1'b0;
            mw_mem_to_reg <= 1'b0;
            mw_alu_result <= '0;
            mw_mem_data   <= '0;
            mw_rd         <= '0;
            mw_exc        <= 1'b0;
        end else if (mw_load) begin
            mw_reg_write  <= em_reg_write & ~mw_exc_nxt;
            mw_mem_to_reg <= em_mem_to_reg;
            mw_alu_result <= em_alu_result;
            mw_mem_data   <= mw_data_nxt;
            mw_rd         <= em_rd;
            mw_exc        <= mw_exc_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: the driver pushes the expected MEM/WB payload
// per instruction; a monitor pops and compares on every edge where MEM/WB captures.
module tb_mem_stage_ctrl;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
    } mw_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        em_mem_read = 1'b0;
    logic        em_mem_write = 1'b0;
    logic        em_reg_write = 1'b0;
    logic        em_mem_to_reg = 1'b0;
    logic [31:0] em_alu_result = '0;
    logic [31:0] em_store_data = '0;
    logic [4:0]  em_rd = '0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        stall;
    logic        mw_reg_write;
    logic        mw_mem_to_reg;
    logic [31:0] mw_alu_result;
    logic [31:0] mw_mem_data;
    logic [4:0]  mw_rd;
    logic        mw_exc;

    int n_cmp = 0;
    int n_err = 0;

    mw_t exp_q[$];
    mw_t e_pop;

    bit          tb_active = 1'b0;
    bit          cap_pending = 1'b0;
    bit          mem_en = 1'b1;
    bit          stray_ack = 1'b0;
    int          mem_lat = 1;
    logic [31:0] mem_rdata = '0;
    int          req_cnt = 0;
    int          req_cycles = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
        .em_reg_write(em_reg_write), .em_mem_to_reg(em_mem_to_reg),
        .em_alu_result(em_alu_result), .em_store_data(em_store_data), .em_rd(em_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .mw_reg_write(mw_reg_write), .mw_mem_to_reg(mw_mem_to_reg),
        .mw_alu_result(mw_alu_result), .mw_mem_data(mw_mem_data),
        .mw_rd(mw_rd), .mw_exc(mw_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mw_t mk(input logic rw, input logic m2r, input logic [31:0] alu,
                               input logic [31:0] data, input logic [4:0] rd, input logic exc);
        mw_t m;
        m.rw = rw; m.m2r = m2r; m.alu = alu; m.data = data; m.rd = rd; m.exc = exc;
        return m;
    endfunction

    // Memory model: ack on the mem_lat-th cycle of dm_req; rdata is junk outside ack.
    always @(posedge clk) begin
        #1;
        if (mem_en && reset && dm_req) begin
            req_cnt++;
            dm_ack = (req_cnt == mem_lat);
        end else begin
            req_cnt = 0;
            dm_ack  = stray_ack;
        end
        dm_rdata = dm_ack && dm_req ? mem_rdata : 32'hBADBAD00;
    end

    // Request-side monitor: counts request cycles and checks the held request fields.
    always @(negedge clk) begin
        cap_pending = tb_active && reset && !stall;
        if (tb_active && dm_req) begin
            req_cycles++;
            check("dm_we", 32'(dm_we), 32'(exp_we));
            check("dm_addr", dm_addr, exp_addr);
            if (exp_we) check("dm_wdata", dm_wdata, exp_wdata);
        end
    end

    // MEM/WB monitor.
    always @(posedge clk) begin
        #1;
        if (cap_pending) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mw_unexpected: capture with empty queue, got rd=%0d", mw_rd);
            end else begin
                e_pop = exp_q.pop_front();
                check("mw_reg_write", 32'(mw_reg_write), 32'(e_pop.rw));
                check("mw_mem_to_reg", 32'(mw_mem_to_reg), 32'(e_pop.m2r));
                check("mw_alu_result", mw_alu_result, e_pop.alu);
                check("mw_mem_data", mw_mem_data, e_pop.data);
                check("mw_rd", 32'(mw_rd), 32'(e_pop.rd));
                check("mw_exc", 32'(mw_exc), 32'(e_pop.exc));
            end
        end
    end

    // Present one instruction, hold it while stalled, check latency and request count.
    task automatic issue(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input int lat_n, input logic [31:0] rdata, input mw_t exp,
                         input int exp_lat, input int exp_req);
        int  cycles;
        bit  s;
        em_mem_read   = rd_en;
        em_mem_write  = wr_en;
        em_reg_write  = rw;
        em_mem_to_reg = m2r;
        em_alu_result = alu;
        em_store_data = sd;
        em_rd         = rd;
        mem_lat       = lat_n;
        mem_rdata     = rdata;
        exp_we        = wr_en;
        exp_addr      = alu;
        exp_wdata     = sd;
        req_cycles    = 0;
        exp_q.push_back(exp);
        cycles = 0;
        forever begin
            @(negedge clk);
            s = stall;
            @(posedge clk);
            cycles++;
            #2;
            if (!s) break;
            if (cycles > 60) begin
                n_cmp++;
                n_err++;
                $display("FAIL stall_timeout: still stalled after %0d cycles", cycles);
                break;
            end
        end
        check("latency", 32'(cycles), 32'(exp_lat));
        check("req_cycles", 32'(req_cycles), 32'(exp_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low with an aligned load on the inputs: no request, no stall.
        em_mem_read   = 1'b1;
        em_reg_write  = 1'b1;
        em_alu_result = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        check("rst_mw_reg_write", 32'(mw_reg_write), 32'd0);
        check("rst_mw_alu_result", mw_alu_result, 32'd0);
        check("rst_mw_rd", 32'(mw_rd), 32'd0);
        check("rst_mw_exc", 32'(mw_exc), 32'd0);
        @(posedge clk);
        #2;
        reset     = 1'b1;
        tb_active = 1'b1;

        // ALU op.
        issue(0, 0, 1, 0, 32'h10, 32'h0, 5'd5, 1, 32'h0,
              mk(1, 0, 32'h10, 32'h0, 5'd5, 0), 1, 0);
        // Load, ack on 3rd WAIT cycle.
        issue(1, 0, 1, 1, 32'h40, 32'h55, 5'd7, 3, 32'hDEADBEEF,
              mk(1, 1, 32'h40, 32'hDEADBEEF, 5'd7, 0), 4, 3);
        // Store, immediate ack.
        issue(0, 1, 0, 0, 32'h80, 32'h1234, 5'd0, 1, 32'h0,
              mk(0, 0, 32'h80, 32'h0, 5'd0, 0), 2, 1);
        // Misaligned load.
        issue(1, 0, 1, 1, 32'h42, 32'h0, 5'd9, 1, 32'h0,
              mk(0, 1, 32'h42, 32'h0, 5'd9, 1), 1, 0);
        // Back-to-back loads.
        issue(1, 0, 1, 1, 32'h100, 32'h0, 5'd3, 2, 32'hCAFEF00D,
              mk(1, 1, 32'h100, 32'hCAFEF00D, 5'd3, 0), 3, 2);
        issue(1, 0, 1, 1, 32'h104, 32'h0, 5'd4, 1, 32'h0BADF00D,
              mk(1, 1, 32'h104, 32'h0BADF00D, 5'd4, 0), 2, 1);
        // Read and write both set: store.
        issue(1, 1, 0, 0, 32'h200, 32'hA5A5A5A5, 5'd2, 2, 32'h11111111,
              mk(0, 0, 32'h200, 32'h0, 5'd2, 0), 3, 2);
        // Misaligned store.
        issue(0, 1, 0, 0, 32'h203, 32'h77, 5'd0, 1, 32'h0,
              mk(0, 0, 32'h203, 32'h0, 5'd0, 1), 1, 0);
        // Stray acks while idle are ignored.
        stray_ack = 1'b1;
        issue(0, 0, 1, 0, 32'h12345678, 32'h0, 5'd11, 1, 32'h0,
              mk(1, 0, 32'h12345678, 32'h0, 5'd11, 0), 1, 0);
        issue(0, 0, 1, 1, 32'h9ABC, 32'h0, 5'd12, 1, 32'h0,
              mk(1, 1, 32'h9ABC, 32'h0, 5'd12, 0), 1, 0);
        stray_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 4 WAIT cycles.
        issue(1, 0, 1, 1, 32'h300, 32'h0, 5'd6, 1000, 32'h0,
              mk(0, 1, 32'h300, 32'h0, 5'd6, 1), 5, 4);
`endif

        // Reset asserted mid-access, then a late ack.
        tb_active     = 1'b0;
        mem_en        = 1'b0;
        em_mem_read   = 1'b1;
        em_mem_write  = 1'b0;
        em_reg_write  = 1'b1;
        em_mem_to_reg = 1'b1;
        em_alu_result = 32'h400;
        em_rd         = 5'd13;
        @(posedge clk);
        @(negedge clk);
        check("wait_dm_req", 32'(dm_req), 32'd1);
        check("wait_stall", 32'(stall), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_dm_req", 32'(dm_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mw_reg_write", 32'(mw_reg_write), 32'd0);
        check("midrst_mw_mem_to_reg", 32'(mw_mem_to_reg), 32'd0);
        check("midrst_mw_alu_result", mw_alu_result, 32'd0);
        check("midrst_mw_rd", 32'(mw_rd), 32'd0);
        @(posedge clk);
        #3;
        dm_ack   = 1'b1;
        dm_rdata = 32'hFEEDFACE;
        @(negedge clk);
        check("lateack_dm_req", 32'(dm_req), 32'd0);
        check("lateack_mw_mem_data", mw_mem_data, 32'd0);
        @(posedge clk);
        #3;
        dm_ack        = 1'b0;
        em_mem_read   = 1'b0;
        em_reg_write  = 1'b0;
        em_mem_to_reg = 1'b0;
        em_alu_result = '0;
        em_rd         = '0;
        @(posedge clk);
        #2;
        reset     = 1'b1;
        mem_en    = 1'b1;
        tb_active = 1'b1;
        // FSM must be back in IDLE: ALU op completes in one cycle.
        issue(0, 0, 1, 0, 32'h99, 32'h0, 5'd14, 1, 32'h0,
              mk(1, 0, 32'h99, 32'h0, 5'd14, 0), 1, 0);
        // And a load still works afterwards.
        issue(1, 0, 1, 1, 32'h500, 32'h0, 5'd15, 2, 32'h13579BDF,
              mk(1, 1, 32'h500, 32'h13579BDF, 5'd15, 0), 3, 2);

        tb_active = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
